// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory / write-back stage. Accepts one operation at a time
//                from execute, retires ALU results straight to the register
//                file, issues aligned load/store requests to memory and
//                extends load data back into the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 8,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  // operation from execute
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [REG_ID_W-1:0] in_rd,
  // memory request
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [XLEN-1:0]     mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_be,
  // memory response
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_data,
  // register-file write port
  output logic [XLEN-1:0]     regs_data_out,
  output logic [REG_ID_W-1:0] regs_wr_id_out,
  output logic                regs_write_out,
  // status
  output logic                misalign_err,
  output logic                busy
);

  localparam int c_NB    = XLEN / 8;
  localparam int c_OFF_W = $clog2(c_NB);

  localparam logic [1:0] c_OP_NONE  = 2'd0;
  localparam logic [1:0] c_OP_ALU   = 2'd1;
  localparam logic [1:0] c_OP_LOAD  = 2'd2;
  localparam logic [1:0] c_OP_STORE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // captured request / load context
  logic [XLEN-1:0]     r_req_addr;
  logic [XLEN-1:0]     r_req_wdata;
  logic [c_NB-1:0]     r_req_be;
  logic                r_req_write;
  logic [c_OFF_W-1:0]  r_off;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [REG_ID_W-1:0] r_rd;

  // register-file port and status
  logic [XLEN-1:0]     r_regs_data;
  logic [REG_ID_W-1:0] r_regs_id;
  logic                r_regs_write;
  logic                r_misalign;

  // combinational helpers
  logic                w_accept;
  logic                w_is_mem;
  logic                w_misalign;
  logic                w_alu_rd_ok;
  logic                w_load_rd_ok;
  logic [c_OFF_W-1:0]  w_off;
  logic [c_NB-1:0]     w_be_mask;
  logic [c_NB-1:0]     w_be;
  logic [XLEN-1:0]     w_wdata_rep;
  logic [XLEN-1:0]     w_req_addr;
  logic [XLEN-1:0]     w_lane;
  logic                w_sign;
  logic [XLEN-1:0]     w_load_data;
  logic                w_rsp_take;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_is_mem   = (in_op == c_OP_LOAD) || (in_op == c_OP_STORE);
  assign w_off      = in_addr[c_OFF_W-1:0];
  assign w_req_addr = {in_addr[XLEN-1:c_OFF_W], {c_OFF_W{1'b0}}};
  assign w_be       = w_be_mask << w_off;
  assign w_rsp_take = (r_state == ST_WAIT) && mem_rsp_valid;

  // Register id 0 is hardwired when ZERO_REG is set: the op still retires
  // but no write is presented to the register file.
  assign w_alu_rd_ok  = !(ZERO_REG && (in_rd == '0));
  assign w_load_rd_ok = !(ZERO_REG && (r_rd == '0));

  // Alignment check; dword is illegal on a 32-bit datapath.
  always_comb begin
    w_misalign = 1'b0;
    case (in_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = in_addr[0];
      2'd2:    w_misalign = |in_addr[1:0];
      default: w_misalign = (XLEN == 32) ? 1'b1 : |in_addr[2:0];
    endcase
  end

  // Byte-enable mask for the access size before shifting into its lane.
  always_comb begin
    w_be_mask = '0;
    case (in_size)
      2'd0:    w_be_mask = c_NB'(1);
      2'd1:    w_be_mask = c_NB'(3);
      2'd2:    w_be_mask = c_NB'(15);
      default: w_be_mask = '1;
    endcase
  end

  // Replicate the low 2^size bytes of store data across the whole bus so the
  // memory can pick whichever lane the byte enables select.
  always_comb begin
    w_wdata_rep = '0;
    for (int b = 0; b < c_NB; b++) begin
      case (in_size)
        2'd0:    w_wdata_rep[b*8 +: 8] = in_wdata[7:0];
        2'd1:    w_wdata_rep[b*8 +: 8] = in_wdata[(b % 2)*8 +: 8];
        2'd2:    w_wdata_rep[b*8 +: 8] = in_wdata[(b % 4)*8 +: 8];
        default: w_wdata_rep[b*8 +: 8] = in_wdata[b*8 +: 8];
      endcase
    end
  end

  // Move the addressed lane to bit 0 and extend it to full width.
  always_comb begin
    w_lane = mem_rsp_data >> {r_off, 3'b000};
    w_sign = 1'b0;
    case (r_size)
      2'd0:    w_sign = w_lane[7];
      2'd1:    w_sign = w_lane[15];
      2'd2:    w_sign = w_lane[31];
      default: w_sign = w_lane[XLEN-1];
    endcase
    w_load_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < (8 << r_size)) begin
        w_load_data[i] = w_lane[i];
      end else begin
        w_load_data[i] = w_sign & ~r_unsigned;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mem && !w_misalign) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = r_req_write ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture request context on acceptance; hold it steady through REQ/WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_be    <= '0;
      r_req_write <= 1'b0;
      r_off       <= '0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_rd        <= '0;
    end else if (w_accept && w_is_mem && !w_misalign) begin
      r_req_addr  <= w_req_addr;
      r_req_wdata <= w_wdata_rep;
      r_req_be    <= w_be;
      r_req_write <= (in_op == c_OP_STORE);
      r_off       <= w_off;
      r_size      <= in_size;
      r_unsigned  <= in_unsigned;
      r_rd        <= in_rd;
    end
  end

  // Register-file write pulses and the misalignment pulse; data/id hold
  // their previous value whenever no write is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs_data  <= '0;
      r_regs_id    <= '0;
      r_regs_write <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_regs_write <= 1'b0;
      r_misalign   <= 1'b0;
      if (w_accept) begin
        case (in_op)
          c_OP_ALU: begin
            if (w_alu_rd_ok) begin
              r_regs_write <= 1'b1;
              r_regs_data  <= in_alu_result;
              r_regs_id    <= in_rd;
            end
          end
          c_OP_LOAD, c_OP_STORE: begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end
          end
          c_OP_NONE: ;
          default: ;
        endcase
      end
      if (w_rsp_take && w_load_rd_ok) begin
        r_regs_write <= 1'b1;
        r_regs_data  <= w_load_data;
        r_regs_id    <= r_rd;
      end
    end
  end

  assign in_ready       = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign mem_req_valid  = (r_state == ST_REQ);
  assign mem_req_write  = r_req_write;
  assign mem_req_addr   = r_req_addr;
  assign mem_req_wdata  = r_req_wdata;
  assign mem_req_be     = r_req_be;
  assign regs_data_out  = r_regs_data;
  assign regs_wr_id_out = r_regs_id;
  assign regs_write_out = r_regs_write;
  assign misalign_err   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_alu_result;
  logic [7:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] regs_data_out;
  logic [7:0]  regs_wr_id_out;
  logic        regs_write_out;
  logic        misalign_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(
    .XLEN     (32),
    .REG_ID_W (8),
    .ZERO_REG (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_alu_result  (in_alu_result),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .regs_data_out  (regs_data_out),
    .regs_wr_id_out (regs_wr_id_out),
    .regs_write_out (regs_write_out),
    .misalign_err   (misalign_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] alu, input logic [7:0] rd);
    in_valid      = 1'b1;
    in_op         = op;
    in_size       = size;
    in_unsigned   = uns;
    in_addr       = addr;
    in_wdata      = wdata;
    in_alu_result = alu;
    in_rd         = rd;
    tick();
    in_valid      = 1'b0;
  endtask

  // Full load: accept, request handshake, response. Returns after the
  // response edge, when the register write should be visible.
  task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [7:0] rd, input logic [31:0] rsp);
    issue(2'd2, size, uns, addr, 32'h0, 32'h0, rd);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    in_valid      = 1'b0;
    in_op         = 2'd0;
    in_size       = 2'd0;
    in_unsigned   = 1'b0;
    in_addr       = 32'h0;
    in_wdata      = 32'h0;
    in_alu_result = 32'h0;
    in_rd         = 8'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;

    // ---- reset state
    tick();
    tick();
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_regs_write", regs_write_out, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs_data", regs_data_out, 0);
    chk("rst_regs_id", regs_wr_id_out, 0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // ---- ALU write-back
    issue(2'd1, 2'd0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'd5);
    chk("alu_write", regs_write_out, 1);
    chk("alu_id", regs_wr_id_out, 5);
    chk("alu_data", regs_data_out, 32'hDEADBEEF);
    chk("alu_in_ready", in_ready, 1);
    tick();
    chk("alu_pulse_end", regs_write_out, 0);
    chk("alu_data_hold", regs_data_out, 32'hDEADBEEF);

    // ---- NONE: nothing happens
    issue(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h12345678, 8'd6);
    chk("none_write", regs_write_out, 0);
    chk("none_req", mem_req_valid, 0);
    chk("none_busy", busy, 0);

    // ---- signed byte load, lane 3
    issue(2'd2, 2'd0, 1'b0, 32'h00001003, 32'h0, 32'h0, 8'd7);
    chk("lb_req_valid", mem_req_valid, 1);
    chk("lb_req_addr", mem_req_addr, 32'h00001000);
    chk("lb_req_be", mem_req_be, 4'b1000);
    chk("lb_req_write", mem_req_write, 0);
    chk("lb_in_ready", in_ready, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("lb_wait_busy", busy, 1);
    chk("lb_wait_req", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FFFFFF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("lb_write", regs_write_out, 1);
    chk("lb_id", regs_wr_id_out, 7);
    chk("lb_data", regs_data_out, 32'hFFFFFF80);
    chk("lb_in_ready", in_ready, 1);

    // ---- unsigned byte load, same lane
    do_load(2'd0, 1'b1, 32'h00001003, 8'd8, 32'h80FFFFFF);
    chk("lbu_write", regs_write_out, 1);
    chk("lbu_data", regs_data_out, 32'h00000080);

    // ---- signed half load, upper lane
    do_load(2'd1, 1'b0, 32'h00007002, 8'd10, 32'h80010000);
    chk("lh_data", regs_data_out, 32'hFFFF8001);
    chk("lh_id", regs_wr_id_out, 10);

    // ---- store half with back-pressure
    mem_req_ready = 1'b0;
    issue(2'd3, 2'd1, 1'b0, 32'h00002002, 32'h1234ABCD, 32'h0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("sh_valid", mem_req_valid, 1);
      chk("sh_addr", mem_req_addr, 32'h00002000);
      chk("sh_be", mem_req_be, 4'b1100);
      chk("sh_wdata", mem_req_wdata, 32'hABCDABCD);
      chk("sh_write", mem_req_write, 1);
      chk("sh_in_ready", in_ready, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("sh_hs_valid", mem_req_valid, 1);
    chk("sh_hs_in_ready", in_ready, 0);
    tick();
    mem_req_ready = 1'b0;
    chk("sh_done_in_ready", in_ready, 1);
    chk("sh_done_valid", mem_req_valid, 0);
    chk("sh_no_regs_write", regs_write_out, 0);

    // ---- misaligned word load
    issue(2'd2, 2'd2, 1'b0, 32'h00003001, 32'h0, 32'h0, 8'd9);
    chk("mis_err", misalign_err, 1);
    chk("mis_req", mem_req_valid, 0);
    chk("mis_write", regs_write_out, 0);
    chk("mis_in_ready", in_ready, 1);
    tick();
    chk("mis_err_end", misalign_err, 0);
    chk("mis_req_after", mem_req_valid, 0);

    // ---- dword is illegal on a 32-bit datapath
    issue(2'd3, 2'd3, 1'b0, 32'h00004000, 32'h0, 32'h0, 8'd0);
    chk("dw_err", misalign_err, 1);
    chk("dw_busy", busy, 0);

    // ---- load to x0: response consumed, no write, data held
    do_load(2'd2, 1'b0, 32'h00005000, 8'd0, 32'h11223344);
    chk("x0_write", regs_write_out, 0);
    chk("x0_data_hold", regs_data_out, 32'hFFFF8001);
    chk("x0_id_hold", regs_wr_id_out, 10);
    chk("x0_idle", busy, 0);
    chk("x0_in_ready", in_ready, 1);

    // ---- response while idle is ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55555555;
    tick();
    mem_rsp_valid = 1'b0;
    chk("idle_rsp_write", regs_write_out, 0);

    // ---- reset during WAIT, late response after release
    issue(2'd2, 2'd2, 1'b0, 32'h00006004, 32'h0, 32'h0, 8'd3);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rw_rst_busy", busy, 0);
    chk("rw_rst_valid", mem_req_valid, 0);
    chk("rw_rst_data", regs_data_out, 0);
    chk("rw_rst_id", regs_wr_id_out, 0);
    #1;
    reset = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hAAAAAAAA;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rw_late_write", regs_write_out, 0);
    chk("rw_late_data", regs_data_out, 0);
    chk("rw_in_ready", in_ready, 1);
    chk("rw_idle", busy, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter REG_ID_W, default 8, destination register id width.
REQ-003 Parameter ZERO_REG, default 1; when 1, writes to register id 0 SHALL be suppressed.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1 / in_ready  output  1  operation handshake from execute; transfer when both high at a rising edge.
REQ-007 in_op  input  2  operation: 0 NONE, 1 ALU, 2 LOAD, 3 STORE.
REQ-008 in_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 in_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 in_addr  input  XLEN / in_wdata  input  XLEN / in_alu_result  input  XLEN / in_rd  input  REG_ID_W  operands.
REQ-011 mem_req_valid  output  1 / mem_req_ready  input  1  memory request handshake.
REQ-012 mem_req_write  output  1 / mem_req_addr  output  XLEN (aligned to XLEN/8 bytes) / mem_req_wdata  output  XLEN / mem_req_be  output  XLEN/8  request fields.
REQ-013 mem_rsp_valid  input  1 / mem_rsp_data  input  XLEN  load response, one per load request.
REQ-014 regs_data_out  output  XLEN / regs_wr_id_out  output  REG_ID_W / regs_write_out  output  1  register-file write port.
REQ-015 misalign_err  output  1  one-cycle pulse on a misaligned or illegal-size access.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, REQ, WAIT; in_ready SHALL equal (state==IDLE).
REQ-018 IDLE: ALU accepted at edge N -> regs_write_out=1, regs_data_out=in_alu_result, regs_wr_id_out=in_rd during cycle N+1; state stays IDLE.
REQ-019 IDLE: NONE accepted -> no write, no request, stays IDLE.
REQ-020 IDLE: aligned LOAD/STORE accepted -> operands registered, state REQ from next cycle.
REQ-021 Misaligned (addr mod 2^size != 0) or size 3 with XLEN=32 -> no memory request, no register write, misalign_err=1 for the following cycle, stays IDLE.
REQ-022 REQ: mem_req_valid=1 with all request fields stable until mem_req_ready sampled high.
REQ-023 mem_req_addr = in_addr with low log2(XLEN/8) bits cleared.
REQ-024 Store: mem_req_be = ((1<<2^size)-1) shifted left by addr low bits; mem_req_wdata = low 2^size bytes of in_wdata replicated across the bus.
REQ-025 Load: mem_req_write=0, mem_req_be as for store.
REQ-026 REQ handshake on store -> IDLE next cycle; on load -> WAIT next cycle.
REQ-027 WAIT: mem_rsp_valid at edge K -> selected lane (shifted right by addr low bits x8), extended to XLEN per in_unsigned, driven on regs port during cycle K+1 with regs_write_out=1; state IDLE at K+1.
REQ-028 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-029 regs_write_out SHALL be a single-cycle pulse per ALU/load; when ZERO_REG=1 and rd==0, regs_write_out stays 0 but the operation otherwise completes.
REQ-030 regs_data_out/regs_wr_id_out SHALL hold their last value when regs_write_out=0.

Reset
REQ-031 reset low SHALL immediately force state IDLE and drive mem_req_valid, regs_write_out, misalign_err, busy to 0, regs_data_out and regs_wr_id_out to 0; in_ready=1 once reset is high.
REQ-032 reset mid-REQ or mid-WAIT SHALL abandon the operation; a late mem_rsp_valid after release SHALL be ignored.

Verification
REQ-033 XLEN=32: ALU rd=5 result 0xDEADBEEF -> next cycle regs_write_out=1, id 5, data 0xDEADBEEF; in_ready stays 1.
REQ-034 Load byte signed addr 0x1003, rsp 0x80FFFFFF -> mem_req_addr 0x1000, be 0b1000, regs_data_out 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Store half addr 0x2002 wdata 0x1234ABCD, mem_req_ready low 3 cycles -> request fields stable, be 0b1100, wdata 0xABCDABCD, in_ready low until 1 cycle after handshake.
REQ-036 Load word addr 0x3001 -> misalign_err pulse 1 cycle, no mem_req_valid, no register write.
REQ-037 Load rd=0 with ZERO_REG=1 -> response consumed, regs_write_out stays 0, returns to IDLE.
REQ-038 Assert reset during WAIT, then send mem_rsp_valid after release -> outputs zero, no register write, in_ready=1.
